hack_rom_loader: RTL and testbench



---
 rtl/hack_pkg.sv | 25 ++
 rtl/hack_rom_mem.sv | 40 ++++
 rtl/hack_rom_loader.sv | 195 +++++++++++++++++++
 tb/tb_hack_rom_loader.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hack_pkg.sv
`default_nettype none
// ============================================================================
// Module  : hack_pkg
// Purpose : Shared types and constants for the Hack instruction-side loader.
//           Holds the loader state encoding and the CPU-facing bus widths.
// Contents: hack_ld_state_t (7 loader states), HACK_PC_W, HACK_WORD_W
// Revision: 1.0 - initial release
// ============================================================================
package hack_pkg;

    localparam int HACK_PC_W   = 15;
    localparam int HACK_WORD_W = 16;

    typedef enum logic [2:0] {
        S_LEN_HI  = 3'd0,
        S_LEN_LO  = 3'd1,
        S_DATA_HI = 3'd2,
        S_DATA_LO = 3'd3,
        S_CKSUM   = 3'd4,
        S_RUN     = 3'd5,
        S_ERROR   = 3'd6
    } hack_ld_state_t;

endpackage : hack_pkg
`default_nettype wire

// File: rtl/hack_rom_mem.sv
`default_nettype none
// ============================================================================
// Module  : hack_rom_mem
// Purpose : DEPTH x 16 instruction ROM storage. One synchronous write port,
//           one combinational (zero-latency) read port. The array has no
//           reset so its contents survive loader resets and reloads.
// Ports   : clk      - write clock
//           i_we     - write enable
//           i_waddr  - write address
//           i_wdata  - write data
//           i_raddr  - read address
//           o_rdata  - read data (combinational)
// Revision: 1.0 - initial release
// ============================================================================
module hack_rom_mem
    import hack_pkg::*;
#(
    parameter int DEPTH  = 4096,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   i_we,
    input  logic [ADDR_W-1:0]      i_waddr,
    input  logic [HACK_WORD_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0]      i_raddr,
    output logic [HACK_WORD_W-1:0] o_rdata
);

    logic [HACK_WORD_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule : hack_rom_mem
`default_nettype wire

// File: rtl/hack_rom_loader.sv
`default_nettype none
// ============================================================================
// Module  : hack_rom_loader
// Purpose : Instruction-side front end of the Hack CPU. Holds the CPU in
//           reset while a big-endian program stream (16-bit count N, then
//           N 16-bit words) arrives over a valid/ready byte interface,
//           writes it into the ROM, then releases the CPU and serves
//           ROM[pc] combinationally.
// Option  : HACK_ROM_CKSUM_EN - stream carries a trailing XOR checksum byte
//           covering both count bytes and all data bytes; a mismatch ends
//           in ERROR with the CPU still held in reset.
// Ports   : CLK          - system clock
//           reset_n      - asynchronous active-low reset
//           rx_data      - byte from UART receiver
//           rx_valid     - rx_data holds a byte
//           rx_ready     - loader accepts a byte (0 only while running)
//           reload       - pulse: abort / clear error, restart loading
//           pc           - CPU program counter
//           instruction  - ROM word at pc while running, else 16'h0000
//           cpu_reset    - registered active-high CPU reset
//           load_busy    - a program is being accepted
//           load_error   - last load failed (sticky until reload)
//           words_loaded - words written in the current or last load
// Revision: 1.0 - initial release
// ============================================================================
module hack_rom_loader
    import hack_pkg::*;
#(
    parameter int DEPTH  = 4096,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic                   CLK,
    input  logic                   reset_n,
    input  logic [7:0]             rx_data,
    input  logic                   rx_valid,
    output logic                   rx_ready,
    input  logic                   reload,
    input  logic [HACK_PC_W-1:0]   pc,
    output logic [HACK_WORD_W-1:0] instruction,
    output logic                   cpu_reset,
    output logic                   load_busy,
    output logic                   load_error,
    output logic [ADDR_W:0]        words_loaded
);

    localparam logic [16:0] c_DEPTH17 = 17'(DEPTH);
    localparam logic [15:0] c_DEPTH16 = 16'(DEPTH);

    hack_ld_state_t         r_state;
    logic [15:0]            r_len;
    logic [7:0]             r_hi;
    logic [ADDR_W-1:0]      r_ptr;
    logic [ADDR_W:0]        r_words;
    logic                   r_cpu_reset;
    logic                   r_load_busy;
    logic                   r_load_error;

    logic                   w_accept;
    logic [15:0]            w_len;
    logic [ADDR_W:0]        w_words_next;
    logic                   w_we;
    logic                   w_pc_ok;
    logic [HACK_WORD_W-1:0] w_rom_word;

    assign rx_ready     = (r_state != S_RUN);
    assign w_accept     = rx_valid & rx_ready;
    // Count as it will stand once the low byte is captured this cycle.
    assign w_len        = {r_len[15:8], rx_data};
    assign w_words_next = r_words + (ADDR_W+1)'(1);
    // reload wins over a byte accepted in the same cycle, including the write.
    assign w_we         = w_accept & ~reload & (r_state == S_DATA_LO);
    assign w_pc_ok      = ({1'b0, pc} < c_DEPTH16);

`ifdef HACK_ROM_CKSUM_EN
    logic [7:0] r_cksum;

    // Running XOR of every stream byte before the checksum byte itself.
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            r_cksum <= 8'h00;
        end else if (reload) begin
            r_cksum <= 8'h00;
        end else if (w_accept) begin
            case (r_state)
                S_LEN_HI:                       r_cksum <= rx_data;
                S_LEN_LO, S_DATA_HI, S_DATA_LO: r_cksum <= r_cksum ^ rx_data;
                default:                        r_cksum <= r_cksum;
            endcase
        end
    end
`endif

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_LEN_HI;
            r_len        <= 16'h0000;
            r_hi         <= 8'h00;
            r_ptr        <= '0;
            r_words      <= '0;
            r_cpu_reset  <= 1'b1;
            r_load_busy  <= 1'b1;
            r_load_error <= 1'b0;
        end else if (reload) begin
            r_state      <= S_LEN_HI;
            r_ptr        <= '0;
            r_words      <= '0;
            r_cpu_reset  <= 1'b1;
            r_load_busy  <= 1'b1;
            r_load_error <= 1'b0;
        end else if (w_accept) begin
            case (r_state)
                S_LEN_HI: begin
                    r_len[15:8] <= rx_data;
                    r_state     <= S_LEN_LO;
                end
                S_LEN_LO: begin
                    r_len[7:0] <= rx_data;
                    if ((w_len == 16'h0000) || ({1'b0, w_len} > c_DEPTH17)) begin
                        r_state      <= S_ERROR;
                        r_load_error <= 1'b1;
                        r_cpu_reset  <= 1'b1;
                        r_load_busy  <= 1'b0;
                    end else begin
                        r_state <= S_DATA_HI;
                        r_ptr   <= '0;
                        r_words <= '0;
                    end
                end
                S_DATA_HI: begin
                    r_hi    <= rx_data;
                    r_state <= S_DATA_LO;
                end
                S_DATA_LO: begin
                    // The pointer may wrap to 0 after the DEPTH-th word; it is
                    // never used again before the next count resets it.
                    r_ptr   <= r_ptr + ADDR_W'(1);
                    r_words <= w_words_next;
                    if (16'(w_words_next) == r_len) begin
`ifdef HACK_ROM_CKSUM_EN
                        r_state <= S_CKSUM;
`else
                        r_state     <= S_RUN;
                        r_cpu_reset <= 1'b0;
                        r_load_busy <= 1'b0;
`endif
                    end else begin
                        r_state <= S_DATA_HI;
                    end
                end
`ifdef HACK_ROM_CKSUM_EN
                S_CKSUM: begin
                    if (rx_data == r_cksum) begin
                        r_state     <= S_RUN;
                        r_cpu_reset <= 1'b0;
                        r_load_busy <= 1'b0;
                    end else begin
                        // New words stay in the ROM; the CPU is kept in reset.
                        r_state      <= S_ERROR;
                        r_load_error <= 1'b1;
                        r_cpu_reset  <= 1'b1;
                        r_load_busy  <= 1'b0;
                    end
                end
`endif
                S_ERROR: begin
                    // Bytes are absorbed and discarded until reload.
                    r_state <= S_ERROR;
                end
                default: begin
                    r_state <= r_state;
                end
            endcase
        end
    end

    hack_rom_mem #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk     (CLK),
        .i_we    (w_we),
        .i_waddr (r_ptr),
        .i_wdata ({r_hi, rx_data}),
        .i_raddr (pc[ADDR_W-1:0]),
        .o_rdata (w_rom_word)
    );

    assign instruction  = ((r_state == S_RUN) && w_pc_ok) ? w_rom_word : 16'h0000;
    assign cpu_reset    = r_cpu_reset;
    assign load_busy    = r_load_busy;
    assign load_error   = r_load_error;
    assign words_loaded = r_words;

endmodule : hack_rom_loader
`default_nettype wire

// File: tb/tb_hack_rom_loader.sv
`default_nettype none
// ============================================================================
// Module  : tb_hack_rom_loader
// Purpose : Directed self-checking bench for hack_rom_loader (DEPTH=4096).
//           Inputs change 1 ns after the rising edge; outputs are sampled
//           there too, so registered results of an edge are visible.
// Revision: 1.0 - initial release
// ============================================================================
module tb_hack_rom_loader;

    localparam int DEPTH = 4096;

    logic        CLK = 1'b0;
    logic        reset_n;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        reload;
    logic [14:0] pc;
    logic [15:0] instruction;
    logic        cpu_reset;
    logic        load_busy;
    logic        load_error;
    logic [12:0] words_loaded;

    int checks   = 0;
    int failures = 0;

    logic [7:0] tx_q[$];

    always #5 CLK = ~CLK;

    hack_rom_loader #(.DEPTH(DEPTH)) dut (
        .CLK          (CLK),
        .reset_n      (reset_n),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .reload       (reload),
        .pc           (pc),
        .instruction  (instruction),
        .cpu_reset    (cpu_reset),
        .load_busy    (load_busy),
        .load_error   (load_error),
        .words_loaded (words_loaded)
    );

    task automatic sync();
        @(posedge CLK);
        #1;
    endtask

    // Present one byte after an optional idle gap and hold it until accepted.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        rx_valid = 1'b0;
        repeat (gap) sync();
        rx_data  = b;
        rx_valid = 1'b1;
        n = 0;
        while (!rx_ready && n < 50) begin
            sync();
            n++;
        end
        checks++;
        if (rx_ready !== 1'b1) begin
            failures++;
            $display("FAIL rx_ready_timeout got=%b exp=1 byte=%h", rx_ready, b);
        end else begin
            sync();
        end
        rx_valid = 1'b0;
    endtask

    task automatic q_start(input logic [15:0] n);
        tx_q.delete();
        tx_q.push_back(n[15:8]);
        tx_q.push_back(n[7:0]);
    endtask

    task automatic q_word(input logic [15:0] w);
        tx_q.push_back(w[15:8]);
        tx_q.push_back(w[7:0]);
    endtask

    task automatic q_end();
`ifdef HACK_ROM_CKSUM_EN
        logic [7:0] x;
        x = 8'h00;
        foreach (tx_q[i]) x ^= tx_q[i];
        tx_q.push_back(x);
`endif
    endtask

    task automatic send_q(input int first, input int last, input int gap_max);
        for (int i = first; i <= last; i++) begin
            send_byte(tx_q[i], (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0);
        end
    endtask

    task automatic pulse_reload();
        reload = 1'b1;
        sync();
        reload = 1'b0;
    endtask

    task automatic test_reset();
        checks++; if (cpu_reset !== 1'b1) begin failures++; $display("FAIL rst_cpu_reset got=%b exp=1", cpu_reset); end
        checks++; if (load_busy !== 1'b1) begin failures++; $display("FAIL rst_load_busy got=%b exp=1", load_busy); end
        checks++; if (load_error !== 1'b0) begin failures++; $display("FAIL rst_load_error got=%b exp=0", load_error); end
        checks++; if (words_loaded !== 13'd0) begin failures++; $display("FAIL rst_words got=%0d exp=0", words_loaded); end
        checks++; if (rx_ready !== 1'b1) begin failures++; $display("FAIL rst_rx_ready got=%b exp=1", rx_ready); end
        checks++; if (instruction !== 16'h0000) begin failures++; $display("FAIL rst_instr got=%h exp=0000", instruction); end
    endtask

    task automatic test_load();
        q_start(16'd2); q_word(16'h1234); q_word(16'hABCD); q_end();
        send_q(0, tx_q.size() - 2, 0);
        checks++; if (cpu_reset !== 1'b1) begin failures++; $display("FAIL load_early_release got=%b exp=1", cpu_reset); end
        send_q(tx_q.size() - 1, tx_q.size() - 1, 0);
        checks++; if (cpu_reset !== 1'b0) begin failures++; $display("FAIL load_cpu_reset got=%b exp=0", cpu_reset); end
        checks++; if (load_busy !== 1'b0) begin failures++; $display("FAIL load_busy got=%b exp=0", load_busy); end
        checks++; if (words_loaded !== 13'd2) begin failures++; $display("FAIL load_words got=%0d exp=2", words_loaded); end
        checks++; if (rx_ready !== 1'b0) begin failures++; $display("FAIL load_rx_ready got=%b exp=0", rx_ready); end
        pc = 15'd0; #1;
        checks++; if (instruction !== 16'h1234) begin failures++; $display("FAIL load_pc0 got=%h exp=1234", instruction); end
        pc = 15'd1; #1;
        checks++; if (instruction !== 16'hABCD) begin failures++; $display("FAIL load_pc1 got=%h exp=abcd", instruction); end
        sync();
    endtask

    task automatic test_bad_count(input logic [15:0] n);
        pulse_reload();
        checks++; if (load_error !== 1'b0 || load_busy !== 1'b1 || cpu_reset !== 1'b1 || words_loaded !== 13'd0) begin
            failures++; $display("FAIL bad_pre_reload err=%b busy=%b rst=%b words=%0d exp=0/1/1/0", load_error, load_busy, cpu_reset, words_loaded);
        end
        send_byte(n[15:8], 0);
        send_byte(n[7:0], 0);
        checks++; if (load_error !== 1'b1) begin failures++; $display("FAIL bad_error n=%h got=%b exp=1", n, load_error); end
        checks++; if (cpu_reset !== 1'b1) begin failures++; $display("FAIL bad_cpu_reset n=%h got=%b exp=1", n, cpu_reset); end
        checks++; if (load_busy !== 1'b0) begin failures++; $display("FAIL bad_busy n=%h got=%b exp=0", n, load_busy); end
        send_byte(8'h55, 0);
        send_byte(8'hAA, 1);
        checks++; if (load_error !== 1'b1 || rx_ready !== 1'b1) begin
            failures++; $display("FAIL bad_absorb err=%b rdy=%b exp=1/1", load_error, rx_ready);
        end
        pulse_reload();
        checks++; if (load_error !== 1'b0 || load_busy !== 1'b1 || cpu_reset !== 1'b1) begin
            failures++; $display("FAIL bad_reload err=%b busy=%b rst=%b exp=0/1/1", load_error, load_busy, cpu_reset);
        end
    endtask

    task automatic test_full_depth();
        pulse_reload();
        q_start(16'(DEPTH));
        for (int i = 0; i < DEPTH; i++) q_word(16'(i * 7 + 3));
        q_end();
        send_q(0, tx_q.size() - 1, 0);
        checks++; if (cpu_reset !== 1'b0 || load_error !== 1'b0) begin
            failures++; $display("FAIL full_run rst=%b err=%b exp=0/0", cpu_reset, load_error);
        end
        checks++; if (words_loaded !== 13'h1000) begin failures++; $display("FAIL full_words got=%0d exp=4096", words_loaded); end
        pc = 15'd0; #1;
        checks++; if (instruction !== 16'h0003) begin failures++; $display("FAIL full_pc0 got=%h exp=0003", instruction); end
        pc = 15'd4095; #1;
        checks++; if (instruction !== 16'h6FFC) begin failures++; $display("FAIL full_pc4095 got=%h exp=6ffc", instruction); end
        pc = 15'd4096; #1;
        checks++; if (instruction !== 16'h0000) begin failures++; $display("FAIL pc_depth got=%h exp=0000", instruction); end
        pc = 15'h7FFF; #1;
        checks++; if (instruction !== 16'h0000) begin failures++; $display("FAIL pc_max got=%h exp=0000", instruction); end
        pc = 15'd0;
        sync();
    endtask

    task automatic test_reload();
        pulse_reload();
        // Byte presented together with reload in LEN_HI must be dropped.
        rx_data = 8'h05; rx_valid = 1'b1; reload = 1'b1;
        sync();
        rx_valid = 1'b0; reload = 1'b0;
        q_start(16'd1); q_word(16'h0003); q_end();
        send_q(0, tx_q.size() - 1, 0);
        checks++; if (cpu_reset !== 1'b0 || words_loaded !== 13'd1) begin
            failures++; $display("FAIL rl_prio rst=%b words=%0d exp=0/1", cpu_reset, words_loaded);
        end
        rx_data = 8'h99; rx_valid = 1'b1; reload = 1'b1;
        sync();
        reload = 1'b0;
        checks++; if (cpu_reset !== 1'b1 || load_busy !== 1'b1 || words_loaded !== 13'd0 || rx_ready !== 1'b1) begin
            failures++; $display("FAIL rl_run rst=%b busy=%b words=%0d rdy=%b exp=1/1/0/1", cpu_reset, load_busy, words_loaded, rx_ready);
        end
        rx_valid = 1'b0;
        q_start(16'd1); q_word(16'h0007); q_end();
        send_q(0, tx_q.size() - 1, 0);
        pc = 15'd0; #1;
        checks++; if (instruction !== 16'h0007 || cpu_reset !== 1'b0) begin
            failures++; $display("FAIL rl_reload_rom got=%h rst=%b exp=0007/0", instruction, cpu_reset);
        end
        sync();
    endtask

    task automatic test_async_reset();
        pulse_reload();
        q_start(16'd4); q_word(16'h1111); q_word(16'h2222); q_word(16'h3333); q_word(16'h4444); q_end();
        send_q(0, 4, 0);
        checks++; if (words_loaded !== 13'd1) begin failures++; $display("FAIL ar_mid_words got=%0d exp=1", words_loaded); end
        #2 reset_n = 1'b0;
        #1;
        checks++; if (cpu_reset !== 1'b1 || words_loaded !== 13'd0 || load_busy !== 1'b1 || rx_ready !== 1'b1) begin
            failures++; $display("FAIL ar_async rst=%b words=%0d busy=%b rdy=%b exp=1/0/1/1", cpu_reset, words_loaded, load_busy, rx_ready);
        end
        #1 reset_n = 1'b1;
        sync();
        q_start(16'd1); q_word(16'hBEEF); q_end();
        send_q(0, tx_q.size() - 1, 0);
        pc = 15'd0; #1;
        checks++; if (instruction !== 16'hBEEF) begin failures++; $display("FAIL ar_pc0 got=%h exp=beef", instruction); end
        pc = 15'd1; #1;
        checks++; if (instruction !== 16'h000A) begin failures++; $display("FAIL ar_stale_pc1 got=%h exp=000a", instruction); end
        sync();
    endtask

    task automatic test_gaps();
        logic [15:0] w [4];
        w[0] = 16'h1357; w[1] = 16'h2468; w[2] = 16'h9ABC; w[3] = 16'hDEF0;
        pulse_reload();
        q_start(16'd4);
        for (int i = 0; i < 4; i++) q_word(w[i]);
        q_end();
        send_q(0, tx_q.size() - 2, 3);
        checks++; if (cpu_reset !== 1'b1) begin failures++; $display("FAIL gap_early_release got=%b exp=1", cpu_reset); end
        send_q(tx_q.size() - 1, tx_q.size() - 1, 3);
        checks++; if (cpu_reset !== 1'b0 || words_loaded !== 13'd4) begin
            failures++; $display("FAIL gap_done rst=%b words=%0d exp=0/4", cpu_reset, words_loaded);
        end
        for (int i = 0; i < 4; i++) begin
            pc = 15'(i); #1;
            checks++; if (instruction !== w[i]) begin failures++; $display("FAIL gap_word%0d got=%h exp=%h", i, instruction, w[i]); end
        end
        sync();
    endtask

`ifdef HACK_ROM_CKSUM_EN
    task automatic test_cksum();
        pulse_reload();
        send_byte(8'h00, 0); send_byte(8'h01, 0); send_byte(8'h7F, 0); send_byte(8'hFF, 0);
        checks++; if (cpu_reset !== 1'b1) begin failures++; $display("FAIL ck_wait got=%b exp=1", cpu_reset); end
        send_byte(8'h81, 0);
        checks++; if (cpu_reset !== 1'b0 || load_error !== 1'b0) begin
            failures++; $display("FAIL ck_good rst=%b err=%b exp=0/0", cpu_reset, load_error);
        end
        pc = 15'd0; #1;
        checks++; if (instruction !== 16'h7FFF) begin failures++; $display("FAIL ck_pc0 got=%h exp=7fff", instruction); end
        sync();
        pulse_reload();
        send_byte(8'h00, 0); send_byte(8'h01, 0); send_byte(8'h7F, 0); send_byte(8'hFF, 0);
        send_byte(8'h80, 0);
        checks++; if (cpu_reset !== 1'b1 || load_error !== 1'b1 || load_busy !== 1'b0) begin
            failures++; $display("FAIL ck_bad rst=%b err=%b busy=%b exp=1/1/0", cpu_reset, load_error, load_busy);
        end
    endtask
`endif

    initial begin
        reset_n  = 1'b0;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        reload   = 1'b0;
        pc       = 15'd0;
        #23 reset_n = 1'b1;
        sync();
        test_reset();
        test_load();
        test_bad_count(16'h0000);
        test_bad_count(16'h1001);
        test_full_depth();
        test_reload();
        test_async_reset();
        test_gaps();
`ifdef HACK_ROM_CKSUM_EN
        test_cksum();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_hack_rom_loader
`default_nettype wire
